jk_mod_counter: RTL
===================

Name: jk_mod_counter

Overview:
- Up/down modulo-N counter whose state is held in a bank of JK flip-flops.
- Per-bit J/K excitation logic computes J/K from count/load controls; this is the stage directly upstream of the flip-flops.
- Serves as the decade/mod-N counting stage for the Chapter 5 sequential-circuit examples.
- Exposes the J/K excitation vectors so benches can check them against excitation tables.

Parameters:
- WIDTH, 4, state width in bits.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RST_B  input  1  asynchronous active-low reset.
- EN  input  1  count enable.
- UP  input  1  direction: 1 counts up, 0 counts down.
- LD  input  1  synchronous parallel load; takes priority over EN.
- D  input  WIDTH  load value.
- Q  output  WIDTH  current count (flip-flop outputs).
- TC  output  1  terminal count, combinational.
- J_EXC  output  WIDTH  per-bit J excitation presented to the flip-flops.
- K_EXC  output  WIDTH  per-bit K excitation presented to the flip-flops.
- WRAP  output  1  sticky wrap flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_B.
- While RST_B=0:
  - Q=0, WRAP=0, independent of CLK.
  - J_EXC, K_EXC and TC follow the combinational rules below with Q=0.
- Reset release: the first posedge with RST_B=1 evaluates controls normally.
- Next state N, by priority:
  - LD=1: N = D if D < MODULUS, else N = MODULUS-1 (out-of-range loads saturate).
  - LD=0, EN=1, UP=1: N = 0 if Q == MODULUS-1, else Q+1.
  - LD=0, EN=1, UP=0: N = MODULUS-1 if Q == 0, else Q-1.
  - LD=0, EN=0: N = Q (hold).
- Excitation per bit i uses minimal JK excitation with don't-cares resolved to 0:
  - J_EXC[i] = N[i] & ~Q[i]
  - K_EXC[i] = ~N[i] & Q[i]
  - Invariant: J_EXC[i] & K_EXC[i] == 0 always; the toggle code 11 is never driven.
  - Hold gives J=K=0 on every bit.
- Latency: Q takes the value N one cycle after the controls are sampled. No pipelining.
- TC = EN & ~LD & (UP ? Q == MODULUS-1 : Q == 0). TC is high during the cycle in which the wrap edge occurs.
- Arithmetic: unsigned WIDTH-bit. Out-of-range states cannot be reached, except through an external force.
  - If Q >= MODULUS, counting up gives N = 0.
  - If Q >= MODULUS, counting down gives N = Q-1 clamped to MODULUS-1.
- Direction change mid-count: takes effect at the next edge, with no dead cycle.
- LD and EN both high: load wins, and TC=0.
- Reset asserted mid-count: Q clears immediately and asynchronously. Any pending LD is lost.

Optional Feature:
- Macro: JK_CTR_WRAP_FLAG_EN.
- Defined:
  - WRAP is set at the posedge on which a wrap occurs (up from MODULUS-1 to 0, or down from 0 to MODULUS-1).
  - WRAP stays set until a load (LD=1) or reset.
  - LD in the same cycle as a would-be wrap: load wins and WRAP clears.
  - Saturating loads do not set WRAP.
- Undefined: WRAP is tied to 0. The port list is unchanged.

Decomposition:
- Shared package jk_ctr_pkg:
  - Default WIDTH/MODULUS constants.
  - Localparam helper MAX_CNT = MODULUS-1.
  - Enum for the excitation codes: HOLD=00, RESET=01, SET=10, TOGGLE=11. Benches use it for checking.
- Sub-module jk_ff_ar, instantiated WIDTH times:
  - Single JK flip-flop with asynchronous active-low reset on CLK/RST_B.
  - Behaviour 00 hold, 01 clear, 10 set, 11 toggle.
- Top level contains next-state logic, excitation logic, TC and WRAP.

Test Plan:
- Reset then up-count: RST_B=0 for 2 cycles, then EN=1, UP=1 for 12 edges -> Q = 1..9, 0, 1, 2; TC=1 only while Q=9; J_EXC=4'b0000, K_EXC=4'b1001 on the 9->0 edge.
- Down wrap: LD=1, D=2, then EN=1, UP=0 -> Q = 2, 1, 0, 9, 8; TC high at Q=0; with JK_CTR_WRAP_FLAG_EN, WRAP=1 from the 0->9 edge onward.
- Load priority and saturation: LD=1, EN=1, D=4'd13 -> Q=9 next cycle, TC=0 during the load cycle; then LD=1, D=4'd5 -> Q=5 and WRAP cleared.
- Hold and direction flip: from Q=6, EN=0 for 3 cycles -> Q stays 6, J_EXC=K_EXC=0; then EN=1 toggling UP each cycle -> Q = 7, 6, 7, 6.
- Async reset mid-count: at Q=7 assert RST_B between clock edges -> Q=0 and WRAP=0 before the next posedge; release and count -> Q=1 on the first edge.
- Invariant sweep: random EN/UP/LD/D for 2000 cycles with MODULUS=10 and with MODULUS=16, WIDTH=4 -> (J_EXC & K_EXC) == 0 every cycle, Q < MODULUS always, Q matches a reference mod-N model.

Source files
------------

// File: rtl/jk_ctr_pkg.sv
// Shared definitions for the JK-flip-flop modulo-N counter.
// Provides default sizing constants, the JK excitation code enum and a helper
// that maps a (present, next) bit pair onto its minimal excitation code.
package jk_ctr_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MODULUS = 10;
    localparam int unsigned MAX_CNT     = DEF_MODULUS - 1;

    // {J,K} codes as presented to a JK flip-flop.
    typedef enum logic [1:0] {
        JkHold   = 2'b00,
        JkReset  = 2'b01,
        JkSet    = 2'b10,
        JkToggle = 2'b11
    } jk_code_e;

    // Minimal excitation with every don't-care resolved to 0, so the toggle
    // code is never produced.
    function automatic jk_code_e jk_excite(input logic q, input logic n);
        jk_code_e code;
        code = JkHold;
        if (n && !q) begin
            code = JkSet;
        end else if (!n && q) begin
            code = JkReset;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_ff_ar.sv
// Single JK flip-flop with asynchronous active-low reset.
// Ports:
//   CLK   - clock, state changes on posedge
//   RST_B - asynchronous active-low reset, clears Q
//   J, K  - excitation: 00 hold, 01 clear, 10 set, 11 toggle
//   Q     - flip-flop output
module jk_ff_ar
    import jk_ctr_pkg::*;
(
    input  logic CLK,
    input  logic RST_B,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_q;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            q_q <= 1'b0;
        end else begin
            unique case (jk_code_e'({J, K}))
                JkHold:   q_q <= q_q;
                JkReset:  q_q <= 1'b0;
                JkSet:    q_q <= 1'b1;
                JkToggle: q_q <= ~q_q;
                default:  q_q <= q_q;
            endcase
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-N counter built from a bank of JK flip-flops.
// The next count is computed combinationally and converted to per-bit J/K
// excitation, which drives the flip-flops and is also exported for checking.
// Optional feature: define JK_CTR_WRAP_FLAG_EN to enable the sticky WRAP flag;
// otherwise WRAP is tied to 0.
// Ports:
//   CLK   - clock, all state changes on posedge
//   RST_B - asynchronous active-low reset (Q=0, WRAP=0)
//   EN    - count enable
//   UP    - direction, 1 up / 0 down
//   LD    - synchronous load, priority over EN
//   D     - load value, saturates to MODULUS-1 when out of range
//   Q     - current count
//   TC    - terminal count (combinational)
//   J_EXC - per-bit J excitation
//   K_EXC - per-bit K excitation
//   WRAP  - sticky wrap flag
module jk_mod_counter
    import jk_ctr_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MODULUS = DEF_MODULUS
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic [WIDTH-1:0] J_EXC,
    output logic [WIDTH-1:0] K_EXC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] q_dec;

    always_comb begin
        n     = q;
        q_dec = q - WIDTH'(1);
        if (LD) begin
            n = ({1'b0, D} < ModExt) ? D : MaxCnt;
        end else if (EN) begin
            if (UP) begin
                // >= also folds out-of-range states back to 0.
                n = (q >= MaxCnt) ? '0 : q + WIDTH'(1);
            end else if (q == '0) begin
                n = MaxCnt;
            end else if (q_dec > MaxCnt) begin
                n = MaxCnt;
            end else begin
                n = q_dec;
            end
        end
    end

    always_comb begin
        jk_code_e code;
        code  = JkHold;
        J_EXC = '0;
        K_EXC = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            code     = jk_excite(q[i], n[i]);
            J_EXC[i] = code[1];
            K_EXC[i] = code[0];
        end
    end

    assign TC = EN & ~LD & (UP ? (q == MaxCnt) : (q == '0));

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ff
        jk_ff_ar u_ff (
            .CLK   (CLK),
            .RST_B (RST_B),
            .J     (J_EXC[i]),
            .K     (K_EXC[i]),
            .Q     (q[i])
        );
    end

    assign Q = q;

`ifdef JK_CTR_WRAP_FLAG_EN
    logic wrap_q;
    logic wrap_d;

    // TC already excludes LD, so a load in a would-be wrap cycle clears.
    always_comb begin
        wrap_d = wrap_q;
        if (LD) begin
            wrap_d = 1'b0;
        end else if (TC) begin
            wrap_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign WRAP = wrap_q;
`else
    assign WRAP = 1'b0;
`endif

endmodule
